wishbone_dm_arbiter: RTL and testbench

Wishbone master and two-way round-robin arbiter in front of the debug-module Wishbone slave (dm.data0, dm.data1, dm.dmcontrol). It accepts single-word read/write commands from two requesters: requester 0 (JTAG DTM/DMI) and requester 1 (UART debug console). It serialises the commands onto one classic-cycle Wishbone bus and returns read data, completion and error status to the owning requester. A bounded timeout ensures a silent slave can never hang either requester.

---
 rtl/wishbone_dm_arbiter_pkg.sv | 23 ++
 rtl/wishbone_dm_arbiter_arb.sv | 25 ++
 rtl/wishbone_dm_arbiter.sv | 156 +++++++++++++++
 tb/tb_wishbone_dm_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_dm_arbiter_pkg.sv
// Shared definitions for the debug-module Wishbone arbiter.
// Contents:
//   state_t  - master FSM state encoding
//   DM_*     - debug-module register addresses on the Wishbone bus
//   *REQ     - dmcontrol bit positions used by both requesters
package wishbone_dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [31:0] DM_DATA0     = 32'h0000_0004;
    localparam logic [31:0] DM_DATA1     = 32'h0000_0005;
    localparam logic [31:0] DM_DMCONTROL = 32'h0000_0010;

    localparam int HALTREQ   = 31;
    localparam int RESUMEREQ = 30;
    localparam int HARTRESET = 29;

endpackage

// File: rtl/wishbone_dm_arbiter_arb.sv
// rr_arbiter2: combinational two-way round-robin pick.
// Ports:
//   pending[1:0] in  - slot n holds a command
//   last_grant   in  - requester granted most recently
//   grant        out - winning requester index (meaningful when valid)
//   valid        out - at least one slot pending
module rr_arbiter2 (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |pending;
        case (pending)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // Tie: hand the bus to whoever did not have it last.
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/wishbone_dm_arbiter.sv
// wishbone_dm_arbiter: two-requester command slots, round-robin arbitration
// and a classic-cycle Wishbone master in front of the debug-module slave.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   req_i/req_we_i            - per-requester command pulse and write enable
//   req_addr_i/req_data_i     - per-requester address (32b) and data (64b)
//   busy_o                    - slot n pending or in flight
//   done_o/err_o/rdata_o      - completion pulse, timeout flag, read data
//   addr_o/we_o/data_o        - Wishbone address, write enable, write data
//   cyc_o/stb_o               - Wishbone cycle/strobe (always equal)
//   data_i/ack_i              - Wishbone read data and acknowledge
module wishbone_dm_arbiter
    import wishbone_dm_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [1:0]   req_i,
    input  logic [1:0]   req_we_i,
    input  logic [63:0]  req_addr_i,
    input  logic [127:0] req_data_i,
    output logic [1:0]   busy_o,
    output logic [1:0]   done_o,
    output logic         err_o,
    output logic [63:0]  rdata_o,
    output logic [31:0]  addr_o,
    output logic         we_o,
    output logic [63:0]  data_o,
    output logic         cyc_o,
    output logic         stb_o,
    input  logic [63:0]  data_i,
    input  logic         ack_i
);

    localparam logic [15:0] TLIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [1:0]        pending;
    logic [1:0]        slot_we;
    logic [1:0][31:0]  slot_addr;
    logic [1:0][63:0]  slot_data;
    logic              grant_q;
    logic              last_grant;
    logic              abort;
    logic [15:0]       tcnt;
    logic              timeout;
    logic              arb_grant;
    logic              arb_valid;

    rr_arbiter2 u_arb (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign timeout = (tcnt == TLIMIT);
    assign busy_o  = pending;

    always_comb begin
        state_nxt = state;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        done_o    = 2'b00;
        err_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) state_nxt = ST_BUS;
            end
            ST_BUS: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                if (ack_i || timeout) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Slave holds ack until cyc drops; wait for it to let go.
                if (!ack_i || timeout) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                done_o    = grant_q ? 2'b10 : 2'b01;
                err_o     = abort;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            pending    <= '0;
            slot_we    <= '0;
            slot_addr  <= '0;
            slot_data  <= '0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            abort      <= 1'b0;
            tcnt       <= '0;
            rdata_o    <= '0;
            addr_o     <= '0;
            we_o       <= 1'b0;
            data_o     <= '0;
        end else begin
            state <= state_nxt;

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q    <= arb_grant;
                        last_grant <= arb_grant;
                        addr_o     <= slot_addr[arb_grant];
                        we_o       <= slot_we[arb_grant];
                        data_o     <= slot_data[arb_grant];
                        tcnt       <= '0;
                        abort      <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (ack_i) begin
                        if (!we_o) rdata_o <= data_i;
                        tcnt <= '0;
                    end else if (timeout) begin
                        abort <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (ack_i) begin
                        if (timeout) abort <= 1'b1;
                        else         tcnt  <= tcnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    pending[grant_q] <= 1'b0;
                end
                default: ;
            endcase

            // Placed after the RESP clear so a new pulse landing on the
            // completing slot is kept rather than lost.
            for (int n = 0; n < 2; n++) begin
                if (req_i[n] && (!pending[n] ||
                                 (state == ST_RESP && grant_q == 1'(n)))) begin
                    pending[n]   <= 1'b1;
                    slot_we[n]   <= req_we_i[n];
                    slot_addr[n] <= req_addr_i[32*n +: 32];
                    slot_data[n] <= req_data_i[64*n +: 64];
                end
            end
        end
    end

endmodule

// File: tb/tb_wishbone_dm_arbiter.sv
module tb_wishbone_dm_arbiter;
    import wishbone_dm_arbiter_pkg::*;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [1:0]   req_i = '0;
    logic [1:0]   req_we_i = '0;
    logic [63:0]  req_addr_i = '0;
    logic [127:0] req_data_i = '0;
    logic [1:0]   busy_o, done_o;
    logic         err_o;
    logic [63:0]  rdata_o;
    logic [31:0]  addr_o;
    logic         we_o;
    logic [63:0]  data_o;
    logic         cyc_o, stb_o;
    logic [63:0]  data_i;
    logic         ack_i;

    always #5 clk = ~clk;

    wishbone_dm_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .addr_o(addr_o),
        .we_o(we_o), .data_o(data_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .data_i(data_i), .ack_i(ack_i)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- DM slave model ----------------
    logic [63:0] mem [256];
    int dly = 0;
    int dcnt;
    bit no_ack = 0;
    bit stuck = 0;

    always @(posedge clk) begin
        if (rst_i) begin
            ack_i  <= 1'b0;
            data_i <= '0;
            dcnt   <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (cyc_o && stb_o && !ack_i && !no_ack) begin
            if (dcnt >= dly) begin
                ack_i <= 1'b1;
                dcnt  <= 0;
                if (we_o) mem[addr_o[7:0]] <= data_o;
                else      data_i <= mem[addr_o[7:0]];
            end else begin
                dcnt <= dcnt + 1;
            end
        end else if (ack_i && !cyc_o && !stuck) begin
            ack_i <= 1'b0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] data;
    } cmd_t;

    cmd_t q0[$];
    cmd_t q1[$];

    function automatic int qsize(input int n);
        return (n == 1) ? q1.size() : q0.size();
    endfunction

    function automatic cmd_t qfront(input int n);
        return (n == 1) ? q1[0] : q0[0];
    endfunction

    logic [63:0] ref_mem [256];
    logic [63:0] m_rdata;
    int          inflight = -1;
    int          m_lg = 1;
    logic [1:0]  snap = '0, snap_prev = '0;
    logic        prev_cyc = 1'b0;
    int          bus_len = 0, rel_len = 0;
    int          done_cnt [2] = '{0, 0};
    int          gseq[$];
    bit          exp_err = 0;
    int          win;
    cmd_t        c;

    always @(negedge clk) begin
        if (rst_i) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            m_rdata  = '0;
            inflight = -1;
            m_lg     = 1;
            snap     = '0;
            prev_cyc = 1'b0;
        end else begin
            chk("busy", {62'd0, busy_o}, {62'd0, qsize(1) != 0, qsize(0) != 0});
            chk("cyc_eq_stb", {63'd0, stb_o}, {63'd0, cyc_o});
            snap_prev = snap;
            snap = {qsize(1) != 0, qsize(0) != 0};

            if (cyc_o && !prev_cyc) begin
                chk("rise_not_in_resp", {62'd0, done_o}, 64'd0);
                if (snap_prev == 2'b11) win = (m_lg == 1) ? 0 : 1;
                else                    win = snap_prev[1] ? 1 : 0;
                chk("grant_has_pending", {63'd0, snap_prev[win]}, 64'd1);
                if (qsize(win) != 0) begin
                    c = qfront(win);
                    chk("bus_addr", {32'd0, addr_o}, {32'd0, c.addr});
                    chk("bus_we", {63'd0, we_o}, {63'd0, c.we});
                    if (c.we) chk("bus_data", data_o, c.data);
                end
                inflight = win;
                m_lg     = win;
                gseq.push_back(win);
                bus_len  = 0;
                rel_len  = 0;
            end

            if (cyc_o) bus_len++;
            if (!cyc_o && inflight >= 0 && done_o == 2'b00) rel_len++;

            if (cyc_o && inflight >= 0 && qsize(inflight) != 0)
                chk("addr_hold", {32'd0, addr_o}, {32'd0, qfront(inflight).addr});

            if (done_o != 2'b00) begin
                chk("done_owner", {62'd0, done_o},
                    (inflight == 1) ? 64'd2 : (inflight == 0) ? 64'd1 : 64'd0);
                if (inflight >= 0 && qsize(inflight) != 0) begin
                    c = qfront(inflight);
                    if (inflight == 1) void'(q1.pop_front());
                    else               void'(q0.pop_front());
                    done_cnt[inflight]++;
                    chk("err", {63'd0, err_o}, {63'd0, exp_err});
                    if (!exp_err) begin
                        if (c.we) ref_mem[c.addr[7:0]] = c.data;
                        else      m_rdata = ref_mem[c.addr[7:0]];
                    end
                    chk("rdata", rdata_o, m_rdata);
                end
                inflight = -1;
            end

            // A slot accepts a pulse only when empty (after any completion this cycle).
            for (int n = 0; n < 2; n++) begin
                if (req_i[n] && qsize(n) == 0) begin
                    c = {req_we_i[n], req_addr_i[32*n +: 32], req_data_i[64*n +: 64]};
                    if (n == 1) q1.push_back(c);
                    else        q0.push_back(c);
                end
            end
            prev_cyc = cyc_o;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] addr_tab [3] = '{DM_DATA0, DM_DATA1, DM_DMCONTROL};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic we, input logic [31:0] a, input logic [63:0] d);
        req_i[n] = 1'b1;
        req_we_i[n] = we;
        req_addr_i[32*n +: 32] = a;
        req_data_i[64*n +: 64] = d;
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (busy_o != 2'b00 && i < 500) begin
            tick();
            i++;
        end
        chk(name, {62'd0, busy_o}, 64'd0);
        tick();
    endtask

    initial begin
        int b0, b1, i;
        logic [63:0] saved;

        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        chk("rst_busy", {62'd0, busy_o}, 64'd0);
        chk("rst_done", {62'd0, done_o}, 64'd0);
        chk("rst_cyc", {63'd0, cyc_o}, 64'd0);
        chk("rst_stb", {63'd0, stb_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_addr", {32'd0, addr_o}, 64'd0);
        chk("rst_data", data_o, 64'd0);

        // Single write to dmcontrol with exact latency.
        b0 = done_cnt[0];
        set_req(0, 1'b1, DM_DMCONTROL, 64'h8000_0000);
        tick();
        req_i = '0;
        chk("lat_cycle1_cyc", {63'd0, cyc_o}, 64'd0);
        chk("lat_cycle1_busy", {62'd0, busy_o}, 64'd1);
        tick();
        chk("lat_cycle2_cyc", {63'd0, cyc_o}, 64'd1);
        wait_idle("w0_idle");
        chk("dmcontrol", mem[8'h10], 64'h8000_0000);
        chk("w0_done_cnt", 64'(done_cnt[0] - b0), 64'd1);

        // Requester 1 write then read back data0.
        b1 = done_cnt[1];
        set_req(1, 1'b1, DM_DATA0, 64'h1234);
        tick(); req_i = '0;
        wait_idle("r1_w_idle");
        set_req(1, 1'b0, DM_DATA0, 64'h0);
        tick(); req_i = '0;
        wait_idle("r1_r_idle");
        chk("readback", rdata_o, 64'h1234);
        chk("r1_done_cnt", 64'(done_cnt[1] - b1), 64'd2);

        // Contention: simultaneous pulses, three rounds.
        gseq.delete();
        repeat (3) begin
            set_req(0, 1'b1, DM_DATA0, {$urandom, $urandom});
            set_req(1, 1'b1, DM_DATA1, {$urandom, $urandom});
            tick(); req_i = '0;
            wait_idle("tie_idle");
        end
        chk("tie_count", 64'(gseq.size()), 64'd6);
        for (int k = 0; k < 6 && k < gseq.size(); k++)
            chk("tie_order", 64'(gseq[k]), 64'(k % 2));

        // Dropped second pulse while busy.
        b0 = done_cnt[0];
        set_req(0, 1'b1, DM_DATA1, 64'hAAAA_0001);
        tick(); req_i = '0;
        chk("drop_busy", {63'd0, busy_o[0]}, 64'd1);
        set_req(0, 1'b1, DM_DATA1, 64'hBBBB_0002);
        tick(); req_i = '0;
        wait_idle("drop_idle");
        repeat (4) tick();
        chk("drop_payload", mem[8'h05], 64'hAAAA_0001);
        chk("drop_done_cnt", 64'(done_cnt[0] - b0), 64'd1);

        // Timeout: silent slave in BUS.
        no_ack = 1; exp_err = 1;
        saved = rdata_o;
        set_req(0, 1'b0, DM_DATA0, 64'h0);
        tick(); req_i = '0;
        wait_idle("to_bus_idle");
        chk("to_bus_len", 64'(bus_len), 64'(TO));
        chk("to_rdata_kept", rdata_o, saved);
        no_ack = 0;

        // Timeout: ack stuck high in RELEASE.
        stuck = 1;
        set_req(1, 1'b1, 32'h20, 64'hDEAD);
        tick(); req_i = '0;
        wait_idle("to_rel_idle");
        chk("to_rel_len", 64'(rel_len), 64'(TO));
        chk("to_rel_rdata_kept", rdata_o, saved);
        stuck = 0; exp_err = 0;
        repeat (3) tick();

        // Reset during BUS with both slots pending.
        no_ack = 1;
        b0 = done_cnt[0] + done_cnt[1];
        set_req(0, 1'b1, DM_DATA0, 64'h11);
        set_req(1, 1'b1, DM_DATA1, 64'h22);
        tick(); req_i = '0;
        i = 0;
        while (!cyc_o && i < 20) begin tick(); i++; end
        chk("rstmid_cyc_seen", {63'd0, cyc_o}, 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstmid_cyc", {63'd0, cyc_o}, 64'd0);
        chk("rstmid_busy", {62'd0, busy_o}, 64'd0);
        no_ack = 0;
        repeat (20) tick();
        chk("rstmid_no_done", 64'(done_cnt[0] + done_cnt[1] - b0), 64'd0);

        // Randomized traffic.
        repeat (400) begin
            dly = $urandom_range(0, 3);
            for (int n = 0; n < 2; n++)
                if ($urandom_range(0, 3) == 0)
                    set_req(n, 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 2)],
                            {$urandom, $urandom});
            tick();
            req_i = '0;
        end
        wait_idle("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule
